// File: rtl/host_csr_pkg.sv
// Shared encodings for the host CSR responder: FSM states, opcodes, register map.
package host_csr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int IDX_CTRL   = 0;
    localparam int IDX_CYCLES = 1;
    localparam int IDX_VAL0   = 2;

    localparam int CTRL_LAUNCH_BIT = 0;
    localparam int CTRL_DONE_BIT   = 1;

endpackage

// File: rtl/host_csr_responder.sv
// Host register-access responder: CTRL/CYCLES/VAL register file, read data one cycle after accept.
// Accepts at most one request every two cycles; the source holds valid until host_req_deq pulses.
module host_csr_responder
    import host_csr_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32,
    parameter int NUM_VALS  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          host_req_valid,
    input  logic                          host_req_opcode,
    input  logic [ADDR_BITS-1:0]          host_req_addr,
    input  logic [DATA_BITS-1:0]          host_req_value,
    output logic                          host_req_deq,
    output logic                          host_resp_valid,
    output logic [DATA_BITS-1:0]          host_resp_bits,
    output logic                          launch,
    input  logic                          finish,
    output logic [NUM_VALS*DATA_BITS-1:0] vals
);

    state_t                r_state;
    logic                  r_resp_valid;
    logic [DATA_BITS-1:0]  r_resp_bits;
    logic                  r_launch;
    logic                  r_done;
    logic [DATA_BITS-1:0]  r_cycles;
    logic [DATA_BITS-1:0]  r_vals [NUM_VALS];

    logic                  w_accept;
    logic                  w_wr;
    logic                  w_ctrl_wr;
    logic                  w_fin;
    logic [31:0]           w_idx;
    logic [DATA_BITS-1:0]  w_rd_data;
    logic                  w_unused_addr;

    // The post-accept RESP/BLANK cycle keeps a source that drops valid late from being dequeued twice.
    assign host_req_deq  = !reset && (r_state == IDLE) && host_req_valid;
    assign w_accept      = host_req_deq;
    assign w_wr          = w_accept && (host_req_opcode == OP_WRITE);
    assign w_idx         = 32'(host_req_addr[ADDR_BITS-1:2]);
    assign w_ctrl_wr     = w_wr && (w_idx == 32'(IDX_CTRL));
    assign w_fin         = finish && r_launch;
    assign w_unused_addr = ^host_req_addr[1:0];

    always_comb begin
        w_rd_data = '0;
        if (w_idx == 32'(IDX_CTRL)) begin
            w_rd_data[CTRL_LAUNCH_BIT] = r_launch;
            w_rd_data[CTRL_DONE_BIT]   = r_done;
        end else if (w_idx == 32'(IDX_CYCLES)) begin
            w_rd_data = r_cycles;
        end else begin
            for (int i = 0; i < NUM_VALS; i++) begin
                if (w_idx == 32'(IDX_VAL0 + i)) begin
                    w_rd_data = r_vals[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_bits  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (w_accept) begin
                        if (host_req_opcode == OP_WRITE) begin
                            r_state <= BLANK;
                        end else begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_bits  <= w_rd_data;
                        end
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                BLANK: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    // Same-edge CTRL write and finish: the written launch bit wins, finish wins over done W1C.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_launch <= 1'b0;
            r_done   <= 1'b0;
            r_cycles <= '0;
            for (int i = 0; i < NUM_VALS; i++) begin
                r_vals[i] <= '0;
            end
        end else begin
            if (w_ctrl_wr) begin
                r_launch <= host_req_value[CTRL_LAUNCH_BIT];
            end else if (w_fin) begin
                r_launch <= 1'b0;
            end

            if (w_fin) begin
                r_done <= 1'b1;
            end else if (w_ctrl_wr && host_req_value[CTRL_DONE_BIT]) begin
                r_done <= 1'b0;
            end

            if (w_ctrl_wr && host_req_value[CTRL_LAUNCH_BIT]) begin
                r_cycles <= '0;
            end else if (r_launch && (r_cycles != '1)) begin
                r_cycles <= r_cycles + {{(DATA_BITS-1){1'b0}}, 1'b1};
            end

            for (int i = 0; i < NUM_VALS; i++) begin
                if (w_wr && (w_idx == 32'(IDX_VAL0 + i))) begin
                    r_vals[i] <= host_req_value;
                end
            end
        end
    end

    assign host_resp_valid = r_resp_valid;
    assign host_resp_bits  = r_resp_bits;
    assign launch          = r_launch;

    for (genvar g = 0; g < NUM_VALS; g++) begin : g_vals
        assign vals[g*DATA_BITS +: DATA_BITS] = r_vals[g];
    end

endmodule

// File: tb/tb_host_csr_responder.sv
// Scoreboard bench for host_csr_responder: expected read data queued at accept, compared on resp strobe.
module tb_host_csr_responder;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         host_req_valid = 1'b0;
    logic         host_req_opcode = 1'b0;
    logic [7:0]   host_req_addr = '0;
    logic [31:0]  host_req_value = '0;
    logic         host_req_deq;
    logic         host_resp_valid;
    logic [31:0]  host_resp_bits;
    logic         launch;
    logic         finish = 1'b0;
    logic [127:0] vals;

    always #5 clock = ~clock;

    host_csr_responder #(.ADDR_BITS(8), .DATA_BITS(32), .NUM_VALS(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .host_req_valid  (host_req_valid),
        .host_req_opcode (host_req_opcode),
        .host_req_addr   (host_req_addr),
        .host_req_value  (host_req_value),
        .host_req_deq    (host_req_deq),
        .host_resp_valid (host_resp_valid),
        .host_resp_bits  (host_resp_bits),
        .launch          (launch),
        .finish          (finish),
        .vals            (vals)
    );

    int           n_checks   = 0;
    int           n_fails    = 0;
    int           n_accepts  = 0;
    int           n_sent     = 0;
    logic [31:0]  exp_q[$];
    logic [127:0] exp_vals   = '0;
    logic         resp_due   = 1'b0;
    logic         noresp_due = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (resp_due) check_eq("resp_after_read", host_resp_valid, 1);
        if (noresp_due) check_eq("no_resp_after_write", host_resp_valid, 0);
        if (host_resp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_resp: got resp 0x%0h with empty scoreboard", host_resp_bits);
            end else begin
                check_eq("resp_data", host_resp_bits, exp_q.pop_front());
            end
        end
        resp_due   = !reset && host_req_deq && !host_req_opcode;
        noresp_due = !reset && host_req_deq && host_req_opcode;
        if (!reset && host_req_deq) n_accepts++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Called 1ns after a rising edge; returns 1ns after the accept edge (plus hold extra cycles).
    task automatic send(input logic op, input logic [7:0] a, input logic [31:0] v,
                        input logic [31:0] exp_rd, input int hold, input logic fin);
        int waited = 0;
        host_req_valid  = 1'b1;
        host_req_opcode = op;
        host_req_addr   = a;
        host_req_value  = v;
        @(negedge clock);
        while (!host_req_deq && waited < 20) begin
            waited++;
            @(negedge clock);
        end
        if (!host_req_deq) begin
            check_eq("deq_timeout", host_req_deq, 1);
            host_req_valid = 1'b0;
            step();
            return;
        end
        n_sent++;
        if (op == 1'b0) exp_q.push_back(exp_rd);
        if (fin) finish = 1'b1;
        step();
        finish = 1'b0;
        repeat (hold) step();
        host_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset with a request already presented: it must not be dequeued.
        host_req_valid = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_deq", host_req_deq, 0);
        check_eq("rst_resp_valid", host_resp_valid, 0);
        check_eq("rst_resp_bits", host_resp_bits, 0);
        check_eq("rst_launch", launch, 0);
        check_eq("rst_vals", vals, 0);
        host_req_valid = 1'b0;
        step();
        reset = 1'b0;
        step();

        // VAL0 write then readback.
        send(1'b1, 8'h08, 32'hDEADBEEF, 32'h0, 0, 1'b0);
        exp_vals[31:0] = 32'hDEADBEEF;
        @(negedge clock);
        check_eq("val0_write", vals, exp_vals);
        step();
        send(1'b0, 8'h08, 32'h0, 32'hDEADBEEF, 0, 1'b0);

        // Launch for exactly 10 cycles, finish in the 10th.
        send(1'b1, 8'h00, 32'h1, 32'h0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_eq("launch_high", launch, 1);
            if (i == 9) finish = 1'b1;
            step();
            finish = 1'b0;
        end
        @(negedge clock);
        check_eq("launch_low_after_finish", launch, 0);
        step();
        send(1'b0, 8'h00, 32'h0, 32'h2, 0, 1'b0);
        send(1'b0, 8'h04, 32'h0, 32'd10, 0, 1'b0);

        // W1C of done, then finish while idle is ignored.
        send(1'b1, 8'h00, 32'h2, 32'h0, 0, 1'b0);
        send(1'b0, 8'h00, 32'h0, 32'h0, 0, 1'b0);
        @(negedge clock);
        finish = 1'b1;
        step();
        finish = 1'b0;
        send(1'b0, 8'h00, 32'h0, 32'h0, 0, 1'b0);

        // Same-edge relaunch + W1C + finish: done stays set, launch stays set, CYCLES restarts.
        send(1'b1, 8'h00, 32'h1, 32'h0, 0, 1'b0);
        send(1'b1, 8'h00, 32'h3, 32'h0, 0, 1'b1);
        send(1'b0, 8'h00, 32'h0, 32'h3, 0, 1'b0);
        send(1'b0, 8'h04, 32'h0, 32'd3, 0, 1'b0);
        send(1'b1, 8'h00, 32'h2, 32'h0, 0, 1'b0);
        send(1'b0, 8'h00, 32'h0, 32'h0, 0, 1'b0);
        send(1'b1, 8'h07, 32'hFFFF, 32'h0, 0, 1'b0);
        send(1'b0, 8'h05, 32'h0, 32'd6, 0, 1'b0);

        // Source keeps valid one cycle past the dequeue.
        send(1'b1, 8'h0C, 32'hCAFEF00D, 32'h0, 1, 1'b0);
        exp_vals[63:32] = 32'hCAFEF00D;
        send(1'b0, 8'h0C, 32'h0, 32'hCAFEF00D, 1, 1'b0);

        // Unmapped and edge-of-map indices.
        send(1'b0, 8'hFC, 32'h0, 32'h0, 0, 1'b0);
        send(1'b1, 8'hFC, 32'h1234, 32'h0, 0, 1'b0);
        send(1'b1, 8'h18, 32'h5555, 32'h0, 0, 1'b0);
        send(1'b1, 8'h17, 32'h0BADC0DE, 32'h0, 0, 1'b0);
        exp_vals[127:96] = 32'h0BADC0DE;
        send(1'b0, 8'h14, 32'h0, 32'h0BADC0DE, 0, 1'b0);
        @(negedge clock);
        check_eq("vals_after_unmapped", vals, exp_vals);
        step();

        // Reset during RESP with a new request held across reset.
        send(1'b1, 8'h00, 32'h1, 32'h0, 0, 1'b0);
        step();
        host_req_valid  = 1'b1;
        host_req_opcode = 1'b0;
        host_req_addr   = 8'h08;
        @(negedge clock);
        check_eq("deq_before_reset", host_req_deq, 1);
        exp_q.push_back(32'hDEADBEEF);
        n_sent++;
        step();
        reset           = 1'b1;
        host_req_opcode = 1'b1;
        host_req_addr   = 8'h0C;
        host_req_value  = 32'h11112222;
        step();
        @(negedge clock);
        check_eq("reset_resp_valid", host_resp_valid, 0);
        check_eq("reset_launch", launch, 0);
        check_eq("reset_vals", vals, 0);
        check_eq("reset_deq_forced", host_req_deq, 0);
        step();
        reset = 1'b0;
        @(negedge clock);
        check_eq("deq_after_reset", host_req_deq, 1);
        n_sent++;
        step();
        host_req_valid = 1'b0;
        exp_vals = '0;
        exp_vals[63:32] = 32'h11112222;
        @(negedge clock);
        check_eq("vals_after_reset_write", vals, exp_vals);
        step();
        send(1'b0, 8'h00, 32'h0, 32'h0, 0, 1'b0);
        send(1'b0, 8'h04, 32'h0, 32'h0, 0, 1'b0);

        repeat (3) step();
        check_eq("scoreboard_empty", exp_q.size(), 0);
        check_eq("accept_count", n_accepts, n_sent);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
